// File: rtl/ysyx_25030085_trap_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_25030085_trap_ctrl_pkg
//   Shared definitions for the machine-mode trap controller:
//   - CSR addresses touched by the trap sequence (mstatus, mtvec, mepc, mcause)
//   - mstatus field masks (MIE, MPIE, MPP)
//   - csr_op write encodings shared by the instruction port and the CSR file
//   - trap sequencer state enum
//   - mstatus transforms applied on trap entry (ecall) and trap return (mret)
// ---------------------------------------------------------------------------
package ysyx_25030085_trap_ctrl_pkg;

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  // mstatus field masks
  localparam logic [31:0] MSTATUS_MIE  = 32'h0000_0008;  // bit 3
  localparam logic [31:0] MSTATUS_MPIE = 32'h0000_0080;  // bit 7
  localparam logic [31:0] MSTATUS_MPP  = 32'h0000_1800;  // bits 12:11

  // CSR write operation encoding (instruction port and CSR file port)
  typedef enum logic [1:0] {
    CSR_OP_NONE  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_RSVD  = 2'b11
  } csr_op_e;

  // Trap sequencer states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_EPC    = 3'd1,
    ST_WR_CAUSE  = 3'd2,
    ST_WR_STATUS = 3'd3,
    ST_REDIRECT  = 3'd4
  } trap_state_e;

  // Trap entry: stash MIE into MPIE, disable interrupts, record M-mode in MPP.
  function automatic logic [31:0] mstatus_ecall(input logic [31:0] status);
    logic [31:0] result;
    result = status & ~(MSTATUS_MIE | MSTATUS_MPIE);
    if ((status & MSTATUS_MIE) != 32'h0) begin
      result = result | MSTATUS_MPIE;
    end
    result = result | MSTATUS_MPP;
    return result;
  endfunction

  // Trap return: restore MIE from MPIE, set MPIE, drop MPP to U-mode.
  function automatic logic [31:0] mstatus_mret(input logic [31:0] status);
    logic [31:0] result;
    result = status & ~(MSTATUS_MIE | MSTATUS_MPIE | MSTATUS_MPP);
    if ((status & MSTATUS_MPIE) != 32'h0) begin
      result = result | MSTATUS_MIE;
    end
    result = result | MSTATUS_MPIE;
    return result;
  endfunction

endpackage

// File: rtl/ysyx_25030085_trap_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_25030085_trap_ctrl
//   Machine-mode trap sequencer sitting in front of a single-write-port CSR
//   file. In IDLE it forwards instruction CSR writes straight through; when a
//   trap request (ecall or mret) arrives it takes over the CSR write port and
//   walks a fixed sequence of writes, then pulses a fetch redirect.
//
//   ecall : IDLE -> WR_EPC -> WR_CAUSE -> WR_STATUS -> REDIRECT(mtvec)
//   mret  : IDLE -> WR_STATUS -> REDIRECT(mepc)
//
// Ports
//   clk, rst           clock; synchronous active-low reset
//   exc_valid/_is_mret trap request (held until exc_ready), 1 = mret
//   exc_pc, exc_cause  trapping PC and mcause value (ecall only)
//   exc_ready          trap request accepted this cycle
//   csri_valid/op/addr/wdata, csri_ready
//                      instruction CSR write request and its accept
//   csr_wen/waddr/wdata  CSR file write port (csr_wen uses csr_op encoding)
//   csr_raddr/rdata    CSR file combinational read port
//   redirect_valid/pc  one-cycle fetch redirect
//   busy               sequencer not in IDLE
// ---------------------------------------------------------------------------
module ysyx_25030085_trap_ctrl
  import ysyx_25030085_trap_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  // trap request
  input  logic            exc_valid,
  input  logic            exc_is_mret,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_cause,
  output logic            exc_ready,
  // instruction CSR write request
  input  logic            csri_valid,
  input  logic [1:0]      csri_op,
  input  logic [11:0]     csri_addr,
  input  logic [XLEN-1:0] csri_wdata,
  output logic            csri_ready,
  // CSR file ports
  output logic [1:0]      csr_wen,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic [11:0]     csr_raddr,
  input  logic [XLEN-1:0] csr_rdata,
  // fetch redirect
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy
);

  trap_state_e     state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] cause_reg, cause_next;
  logic            is_mret_reg, is_mret_next;

  // State and capture registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      pc_reg      <= '0;
      cause_reg   <= '0;
      is_mret_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      cause_reg   <= cause_next;
      is_mret_reg <= is_mret_next;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    cause_next     = cause_reg;
    is_mret_next   = is_mret_reg;
    exc_ready      = 1'b0;
    csri_ready     = 1'b0;
    csr_wen        = CSR_OP_NONE;
    csr_waddr      = '0;
    csr_wdata      = '0;
    csr_raddr      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    unique case (state_reg)
      ST_IDLE: begin
        if (exc_valid) begin
          // A pending trap always wins the write port; the instruction
          // write simply stays stalled behind it.
          exc_ready    = 1'b1;
          pc_next      = exc_pc;
          cause_next   = exc_cause;
          is_mret_next = exc_is_mret;
          state_next   = exc_is_mret ? ST_WR_STATUS : ST_WR_EPC;
        end else begin
          csri_ready = 1'b1;
          // Encodings 00 and 11 complete the handshake without writing.
          if (csri_valid &&
              (csri_op == CSR_OP_WRITE || csri_op == CSR_OP_SET)) begin
            csr_wen   = csri_op;
            csr_waddr = csri_addr;
            csr_wdata = csri_wdata;
          end
        end
      end

      ST_WR_EPC: begin
        csr_wen    = CSR_OP_WRITE;
        csr_waddr  = CSR_MEPC;
        csr_wdata  = pc_reg;
        state_next = ST_WR_CAUSE;
      end

      ST_WR_CAUSE: begin
        csr_wen    = CSR_OP_WRITE;
        csr_waddr  = CSR_MCAUSE;
        csr_wdata  = cause_reg;
        state_next = ST_WR_STATUS;
      end

      ST_WR_STATUS: begin
        // Read-modify-write of mstatus through the combinational read port.
        csr_raddr  = CSR_MSTATUS;
        csr_wen    = CSR_OP_WRITE;
        csr_waddr  = CSR_MSTATUS;
        csr_wdata  = is_mret_reg ? mstatus_mret(csr_rdata)
                                 : mstatus_ecall(csr_rdata);
        state_next = ST_REDIRECT;
      end

      ST_REDIRECT: begin
        redirect_valid = 1'b1;
        if (is_mret_reg) begin
          csr_raddr   = CSR_MEPC;
          redirect_pc = csr_rdata;
        end else begin
          // Direct mode only: the mode bits of mtvec are masked off.
          csr_raddr   = CSR_MTVEC;
          redirect_pc = {csr_rdata[XLEN-1:2], 2'b00};
        end
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // While reset is held every handshake, write and redirect is silenced,
    // so a sequence interrupted by reset leaves no further side effects.
    if (!rst) begin
      exc_ready      = 1'b0;
      csri_ready     = 1'b0;
      csr_wen        = CSR_OP_NONE;
      csr_waddr      = '0;
      csr_wdata      = '0;
      csr_raddr      = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
    end
  end

  assign busy = rst && (state_reg != ST_IDLE);

endmodule

// File: tb/tb_ysyx_25030085_trap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ysyx_25030085_trap_ctrl
//   Bench for the trap sequencer. A CSR file (env_csr) is attached to the
//   DUT's CSR ports. An independent model keeps its own copy of the CSRs
//   (m_csr) and a queue of the trap steps still owed, and every cycle a
//   compare process checks the DUT outputs against it. Directed scenarios
//   pin the model with literal expectations, then random traffic follows.
// ---------------------------------------------------------------------------
module tb_ysyx_25030085_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        exc_valid = 1'b0;
  logic        exc_is_mret = 1'b0;
  logic [31:0] exc_pc = '0;
  logic [31:0] exc_cause = '0;
  logic        exc_ready;
  logic        csri_valid = 1'b0;
  logic [1:0]  csri_op = 2'b00;
  logic [11:0] csri_addr = '0;
  logic [31:0] csri_wdata = '0;
  logic        csri_ready;
  logic [1:0]  csr_wen;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ysyx_25030085_trap_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .exc_valid(exc_valid), .exc_is_mret(exc_is_mret),
    .exc_pc(exc_pc), .exc_cause(exc_cause), .exc_ready(exc_ready),
    .csri_valid(csri_valid), .csri_op(csri_op), .csri_addr(csri_addr),
    .csri_wdata(csri_wdata), .csri_ready(csri_ready),
    .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );

  // ---------------- CSR file environment ----------------
  logic [31:0] env_csr [0:4095] = '{default: 32'h0};
  assign csr_rdata = env_csr[csr_raddr];

  always @(posedge clk) begin
    if (csr_wen == 2'b01)      env_csr[csr_waddr] <= csr_wdata;
    else if (csr_wen == 2'b10) env_csr[csr_waddr] <= env_csr[csr_waddr] | csr_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef enum int {K_EPC, K_CAUSE, K_STATUS, K_REDIR} kind_e;
  typedef struct {
    kind_e       kind;
    logic [31:0] val;
    bit          mret;
  } step_t;

  logic [31:0] m_csr [0:4095] = '{default: 32'h0};
  step_t       steps[$];

  function automatic logic [31:0] ref_ecall(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[7] = s[3];
    r[3] = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  function automatic logic [31:0] ref_mret(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[3] = s[7];
    r[7] = 1'b1;
    r[12:11] = 2'b00;
    return r;
  endfunction

  function automatic step_t mk(input kind_e k, input logic [31:0] v, input bit m);
    step_t s;
    s.kind = k;
    s.val = v;
    s.mret = m;
    return s;
  endfunction

  always @(negedge clk) begin
    step_t s;
    logic [31:0] v;
    logic [1:0]  ew;
    if (!rst) begin
      chk("rst_exc_ready", {31'h0, exc_ready}, 32'h0);
      chk("rst_csri_ready", {31'h0, csri_ready}, 32'h0);
      chk("rst_csr_wen", {30'h0, csr_wen}, 32'h0);
      chk("rst_redirect_valid", {31'h0, redirect_valid}, 32'h0);
      chk("rst_redirect_pc", redirect_pc, 32'h0);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      steps.delete();
    end else if (steps.size() == 0) begin
      chk("idle_busy", {31'h0, busy}, 32'h0);
      chk("idle_redirect_valid", {31'h0, redirect_valid}, 32'h0);
      chk("idle_raddr", {20'h0, csr_raddr}, 32'h0);
      if (exc_valid) begin
        chk("acc_exc_ready", {31'h0, exc_ready}, 32'h1);
        chk("acc_csri_ready", {31'h0, csri_ready}, 32'h0);
        chk("acc_csr_wen", {30'h0, csr_wen}, 32'h0);
        if (!exc_is_mret) begin
          steps.push_back(mk(K_EPC, exc_pc, 1'b0));
          steps.push_back(mk(K_CAUSE, exc_cause, 1'b0));
        end
        steps.push_back(mk(K_STATUS, 32'h0, exc_is_mret));
        steps.push_back(mk(K_REDIR, 32'h0, exc_is_mret));
      end else begin
        chk("idle_exc_ready", {31'h0, exc_ready}, 32'h0);
        chk("idle_csri_ready", {31'h0, csri_ready}, 32'h1);
        ew = (csri_valid && (csri_op == 2'b01 || csri_op == 2'b10)) ? csri_op : 2'b00;
        chk("idle_csr_wen", {30'h0, csr_wen}, {30'h0, ew});
        if (ew != 2'b00) begin
          chk("idle_csr_waddr", {20'h0, csr_waddr}, {20'h0, csri_addr});
          chk("idle_csr_wdata", csr_wdata, csri_wdata);
          if (ew == 2'b01) m_csr[csri_addr] = csri_wdata;
          else             m_csr[csri_addr] = m_csr[csri_addr] | csri_wdata;
        end
      end
    end else begin
      s = steps.pop_front();
      chk("seq_busy", {31'h0, busy}, 32'h1);
      chk("seq_exc_ready", {31'h0, exc_ready}, 32'h0);
      chk("seq_csri_ready", {31'h0, csri_ready}, 32'h0);
      case (s.kind)
        K_EPC, K_CAUSE: begin
          chk("seq_csr_wen", {30'h0, csr_wen}, 32'h1);
          chk("seq_csr_waddr", {20'h0, csr_waddr}, (s.kind == K_EPC) ? 32'h341 : 32'h342);
          chk("seq_csr_wdata", csr_wdata, s.val);
          chk("seq_raddr", {20'h0, csr_raddr}, 32'h0);
          chk("seq_redirect_valid", {31'h0, redirect_valid}, 32'h0);
          m_csr[(s.kind == K_EPC) ? 12'h341 : 12'h342] = s.val;
        end
        K_STATUS: begin
          v = s.mret ? ref_mret(m_csr[12'h300]) : ref_ecall(m_csr[12'h300]);
          chk("status_csr_wen", {30'h0, csr_wen}, 32'h1);
          chk("status_csr_waddr", {20'h0, csr_waddr}, 32'h300);
          chk("status_csr_wdata", csr_wdata, v);
          chk("status_raddr", {20'h0, csr_raddr}, 32'h300);
          chk("status_redirect_valid", {31'h0, redirect_valid}, 32'h0);
          m_csr[12'h300] = v;
        end
        default: begin
          v = s.mret ? m_csr[12'h341] : (m_csr[12'h305] & 32'hFFFF_FFFC);
          chk("redir_valid", {31'h0, redirect_valid}, 32'h1);
          chk("redir_pc", redirect_pc, v);
          chk("redir_csr_wen", {30'h0, csr_wen}, 32'h0);
          chk("redir_raddr", {20'h0, csr_raddr}, s.mret ? 32'h341 : 32'h305);
        end
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    tick();
    exc_valid = 1'b0;
    csri_valid = 1'b1;
    csri_op = op;
    csri_addr = a;
    csri_wdata = d;
    @(negedge clk);
    chk("dir_csri_ready", {31'h0, csri_ready}, 32'h1);
    tick();
    csri_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic trap(input bit m, input logic [31:0] pc, input logic [31:0] cause);
    tick();
    exc_valid = 1'b1;
    exc_is_mret = m;
    exc_pc = pc;
    exc_cause = cause;
    @(negedge clk);
    chk("dir_exc_ready", {31'h0, exc_ready}, 32'h1);
  endtask

  logic [11:0] addr_set [0:4] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h340};

  initial begin
    bit acc_e, acc_c;
    logic [11:0] a;

    // Reset with a trap request pending: nothing may be accepted
    exc_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_exc_ready", {31'h0, exc_ready}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    tick();
    exc_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    // ecall: mstatus=0x8, mtvec=0x80000201
    csr_write(12'h300, 2'b01, 32'h8);
    csr_write(12'h305, 2'b01, 32'h8000_0201);
    trap(1'b0, 32'h8000_0100, 32'hB);
    for (int k = 1; k <= 4; k++) begin
      tick();
      exc_valid = 1'b0;
      @(negedge clk);
      chk("ecall_redirect_valid", {31'h0, redirect_valid}, (k == 4) ? 32'h1 : 32'h0);
      if (k == 4) chk("ecall_redirect_pc", redirect_pc, 32'h8000_0200);
    end
    tick();
    @(negedge clk);
    chk("ecall_mepc", env_csr[12'h341], 32'h8000_0100);
    chk("ecall_mcause", env_csr[12'h342], 32'hB);
    chk("ecall_mstatus", env_csr[12'h300], 32'h1880);

    // mret: mstatus=0x1880 (left by ecall), mepc=0x80000104
    csr_write(12'h341, 2'b01, 32'h8000_0104);
    trap(1'b1, 32'h0, 32'h0);
    for (int k = 1; k <= 2; k++) begin
      tick();
      exc_valid = 1'b0;
      @(negedge clk);
      chk("mret_redirect_valid", {31'h0, redirect_valid}, (k == 2) ? 32'h1 : 32'h0);
      if (k == 2) chk("mret_redirect_pc", redirect_pc, 32'h8000_0104);
    end
    tick();
    @(negedge clk);
    chk("mret_mstatus", env_csr[12'h300], 32'h88);

    // Instruction set-write: same-cycle passthrough
    tick();
    csri_valid = 1'b1;
    csri_op = 2'b10;
    csri_addr = 12'h305;
    csri_wdata = 32'h4;
    @(negedge clk);
    chk("set_csri_ready", {31'h0, csri_ready}, 32'h1);
    chk("set_csr_wen", {30'h0, csr_wen}, 32'h2);
    chk("set_csr_waddr", {20'h0, csr_waddr}, 32'h305);
    tick();
    csri_valid = 1'b0;
    @(negedge clk);

    // Reserved op 11 completes with no write
    tick();
    csri_valid = 1'b1;
    csri_op = 2'b11;
    csri_addr = 12'h342;
    @(negedge clk);
    chk("op11_csri_ready", {31'h0, csri_ready}, 32'h1);
    chk("op11_csr_wen", {30'h0, csr_wen}, 32'h0);
    tick();
    csri_valid = 1'b0;
    @(negedge clk);

    // Trap and CSR write together: trap wins, write waits until after REDIRECT
    tick();
    exc_valid = 1'b1;
    exc_is_mret = 1'b0;
    exc_pc = 32'h8000_0300;
    exc_cause = 32'hB;
    csri_valid = 1'b1;
    csri_op = 2'b01;
    csri_addr = 12'h340;
    csri_wdata = 32'h1234;
    @(negedge clk);
    chk("both_exc_ready", {31'h0, exc_ready}, 32'h1);
    chk("both_csri_ready", {31'h0, csri_ready}, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      exc_valid = 1'b0;
      @(negedge clk);
      chk("both_csri_ready_seq", {31'h0, csri_ready}, (k == 5) ? 32'h1 : 32'h0);
      if (k == 4) chk("both_redirect_pc", redirect_pc, 32'h8000_0204);
      if (k == 5) chk("both_csr_waddr", {20'h0, csr_waddr}, 32'h340);
    end
    tick();
    csri_valid = 1'b0;
    @(negedge clk);

    // Reset during WR_CAUSE: mepc written, mcause untouched, no redirect
    csr_write(12'h342, 2'b01, 32'h55);
    trap(1'b0, 32'h8000_0400, 32'hB);
    tick();
    exc_valid = 1'b0;
    @(negedge clk);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_csr_wen", {30'h0, csr_wen}, 32'h0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      chk("midrst_no_redirect", {31'h0, redirect_valid}, 32'h0);
    end
    chk("midrst_mcause", env_csr[12'h342], 32'h55);
    chk("midrst_mepc", env_csr[12'h341], 32'h8000_0400);

    // Random traffic; requests are held until accepted
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc_e = exc_valid && exc_ready;
      acc_c = csri_valid && csri_ready;
      @(posedge clk);
      #1;
      rst = ($urandom_range(0, 149) != 0);
      if (!exc_valid || acc_e) begin
        exc_valid = ($urandom_range(0, 7) == 0);
        exc_is_mret = $urandom_range(0, 1);
        exc_pc = $urandom;
        exc_cause = $urandom;
      end
      if (!csri_valid || acc_c) begin
        csri_valid = $urandom_range(0, 1);
        csri_op = 2'($urandom_range(0, 3));
        a = addr_set[$urandom_range(0, 4)];
        csri_addr = a;
        csri_wdata = $urandom;
      end
    end
    tick();
    rst = 1'b1;
    exc_valid = 1'b0;
    csri_valid = 1'b0;
    repeat (8) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      a = addr_set[i];
      chk("final_csr_state", env_csr[a], m_csr[a]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
